// File: rtl/shift194_seq_ctrl_if.sv
// Command channel between the lab top-level and the 74HC194 sequencer.
// The master issues commands. The slave (the sequencer) reports readiness and progress.
interface shift194_seq_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [3:0]       cmd_data;
    logic [CNT_W-1:0] cmd_cnt;
    logic             cmd_fill;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_cnt, cmd_fill,
        input  cmd_ready, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_cnt, cmd_fill,
        output cmd_ready, busy, done
    );
endinterface

// File: rtl/shift194_seq_ctrl.sv
// Command-driven sequencer for a 4-bit 74HC194-style universal shift register.
// It runs clear, load, N-step shift and N-step rotate commands by driving MR/S/Dsr/Dsl/D on each cycle.
module shift194_seq_ctrl #(
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    shift194_seq_ctrl_if.slave   cmd,
    input  logic [3:0]           q_fb,
    output logic                 reg_mr_n,
    output logic [1:0]           reg_s,
    output logic                 reg_dsr,
    output logic                 reg_dsl,
    output logic [3:0]           reg_d
);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_CLEAR = 3'b001;
    localparam logic [2:0] OP_LOAD  = 3'b010;
    localparam logic [2:0] OP_SHR   = 3'b011;
    localparam logic [2:0] OP_SHL   = 3'b100;
    localparam logic [2:0] OP_ROR   = 3'b101;
    localparam logic [2:0] OP_ROL   = 3'b110;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [2:0]       op_q;
    logic [3:0]       data_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fill_q;
    logic             ready;
    logic             accept;
    logic             busy_c;
    logic             done_c;
    logic             op_is_right;

    assign ready         = (state == IDLE) && !rst;
    assign accept        = cmd.cmd_valid && ready;
    assign cmd.cmd_ready = ready;
    assign cmd.busy      = busy_c;
    assign cmd.done      = done_c;
    assign op_is_right   = (op_q == OP_SHR) || (op_q == OP_ROR);

    // The command fields are latched only on the accept edge, so the master may change them once the command is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= 3'b000;
            data_q <= 4'b0000;
            cnt_q  <= '0;
            fill_q <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q   <= cmd.cmd_op;
                data_q <= cmd.cmd_data;
                cnt_q  <= cmd.cmd_cnt;
                fill_q <= cmd.cmd_fill;
            end else if (state == SHIFT) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // The outputs are decoded from the current state. The register therefore acts on the same edge that advances the FSM.
    always_comb begin
        state_next = state;
        reg_mr_n   = 1'b1;
        reg_s      = MODE_HOLD;
        reg_dsr    = 1'b0;
        reg_dsl    = 1'b0;
        reg_d      = 4'b0000;
        busy_c     = 1'b0;
        done_c     = 1'b0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    case (cmd.cmd_op)
                        OP_CLEAR: state_next = CLEAR;
                        OP_LOAD:  state_next = LOAD;
                        OP_SHR, OP_SHL, OP_ROR, OP_ROL:
                            state_next = (cmd.cmd_cnt != '0) ? SHIFT : DONE;
                        default:  state_next = DONE;
                    endcase
                end
            end
            CLEAR: begin
                busy_c     = 1'b1;
                reg_mr_n   = 1'b0;
                state_next = DONE;
            end
            LOAD: begin
                busy_c     = 1'b1;
                reg_s      = MODE_LOAD;
                reg_d      = data_q;
                state_next = DONE;
            end
            SHIFT: begin
                busy_c  = 1'b1;
                reg_s   = op_is_right ? MODE_RIGHT : MODE_LEFT;
                // For a rotate, the bit that drops off one end is fed back into the other end.
                reg_dsr = (op_q == OP_ROR) ? q_fb[3] : fill_q;
                reg_dsl = (op_q == OP_ROL) ? q_fb[0] : fill_q;
                if (cnt_q == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy_c     = 1'b1;
                done_c     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (rst) begin
            reg_mr_n = 1'b0;
            reg_s    = MODE_HOLD;
            reg_dsr  = 1'b0;
            reg_dsl  = 1'b0;
            reg_d    = 4'b0000;
            busy_c   = 1'b0;
            done_c   = 1'b0;
        end
    end

endmodule
